// File: rtl/uart_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter_if
// Description : Bundle of requester-side and UART-side signals for the
//               round-robin UART transmit arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_arbiter_if #(
  parameter int NREQ = 3
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_ack;
  logic              tx_rdy_n;
  logic              tx_en;
  logic [2:0]        waddr;
  logic [7:0]        wdata;
  logic              busy;
  logic [1:0]        grant_id;
  logic              timeout_err;
  logic              err_clr;

  // Arbiter side
  modport slave (
    input  req_valid, req_data, tx_rdy_n, err_clr,
    output req_ack, tx_en, waddr, wdata, busy, grant_id, timeout_err
  );

  // Environment side (requesters, UART, error handling)
  modport master (
    output req_valid, req_data, tx_rdy_n, err_clr,
    input  req_ack, tx_en, waddr, wdata, busy, grant_id, timeout_err
  );
endinterface
`default_nettype wire

// File: rtl/uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin arbiter feeding bytes from NREQ requesters into a
//               UART transmit holding register. One write strobe per byte,
//               a fixed hold-off after each write, then a bounded wait for the
//               UART ready flag; a byte whose wait expires is abandoned and
//               flagged in a sticky error bit.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_arbiter #(
  parameter int          NREQ    = 3,
  parameter int          HOLDOFF = 4,
  parameter logic [19:0] TIMEOUT = 20'd540000
) (
  input  logic             clk,
  input  logic             rst,
  uart_tx_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2,
    S_WAIT  = 2'd3
  } state_t;

  state_t      r_state;
  logic        r_tx_en;
  logic [NREQ-1:0] r_req_ack;
  logic [7:0]  r_wdata;
  logic [1:0]  r_grant_id;
  logic [1:0]  r_last_grant;
  logic        r_busy;
  logic        r_timeout_err;
  logic [3:0]  r_hold_cnt;
  logic [19:0] r_wait_cnt;

  state_t      w_state_nxt;
  logic        w_tx_en_nxt;
  logic [NREQ-1:0] w_req_ack_nxt;
  logic [7:0]  w_wdata_nxt;
  logic [1:0]  w_grant_id_nxt;
  logic [1:0]  w_last_grant_nxt;
  logic        w_timeout_err_nxt;
  logic [3:0]  w_hold_cnt_nxt;
  logic [19:0] w_wait_cnt_nxt;

  logic        w_found;
  logic [1:0]  w_sel;
  logic [7:0]  w_sel_data;

  // Round-robin search: first valid requester starting just after last_grant.
  // Indices stay constant after unrolling, so no variable bit-selects appear.
  always_comb begin
    w_found    = 1'b0;
    w_sel      = 2'd0;
    w_sel_data = 8'd0;
    for (int k = 1; k <= NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!w_found && bus.req_valid[i] &&
            ((int'(r_last_grant) + k) % NREQ) == i) begin
          w_found    = 1'b1;
          w_sel      = 2'(i);
          w_sel_data = bus.req_data[8*i +: 8];
        end
      end
    end
  end

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    w_state_nxt       = r_state;
    w_tx_en_nxt       = 1'b0;
    w_req_ack_nxt     = '0;
    w_wdata_nxt       = r_wdata;
    w_grant_id_nxt    = r_grant_id;
    w_last_grant_nxt  = r_last_grant;
    w_hold_cnt_nxt    = r_hold_cnt;
    w_wait_cnt_nxt    = r_wait_cnt;
    // A timeout in the same cycle overrides the clear further down.
    w_timeout_err_nxt = bus.err_clr ? 1'b0 : r_timeout_err;
    case (r_state)
      S_IDLE: begin
        if (!bus.tx_rdy_n && w_found) begin
          w_state_nxt    = S_ISSUE;
          w_tx_en_nxt    = 1'b1;
          w_wdata_nxt    = w_sel_data;
          w_grant_id_nxt = w_sel;
          for (int i = 0; i < NREQ; i++) begin
            w_req_ack_nxt[i] = (w_sel == 2'(i));
          end
        end
      end
      S_ISSUE: begin
        w_state_nxt    = S_HOLD;
        w_hold_cnt_nxt = 4'd0;
      end
      S_HOLD: begin
        // tx_rdy_n is not trustworthy right after a write, so it is ignored.
        if (r_hold_cnt == 4'(HOLDOFF - 1)) begin
          w_state_nxt    = S_WAIT;
          w_wait_cnt_nxt = 20'd0;
        end else begin
          w_hold_cnt_nxt = r_hold_cnt + 4'd1;
        end
      end
      S_WAIT: begin
        if (!bus.tx_rdy_n) begin
          w_state_nxt      = S_IDLE;
          w_last_grant_nxt = r_grant_id;
        end else if (r_wait_cnt == TIMEOUT - 20'd1) begin
          // The requester was already acked, so the byte is dropped, not retried.
          w_state_nxt       = S_IDLE;
          w_last_grant_nxt  = r_grant_id;
          w_timeout_err_nxt = 1'b1;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + 20'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and output registers; reset parks the pointer so requester 0 wins first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_tx_en       <= 1'b0;
      r_req_ack     <= '0;
      r_wdata       <= 8'd0;
      r_grant_id    <= 2'd0;
      r_last_grant  <= 2'(NREQ - 1);
      r_busy        <= 1'b0;
      r_timeout_err <= 1'b0;
      r_hold_cnt    <= 4'd0;
      r_wait_cnt    <= 20'd0;
    end else begin
      r_state       <= w_state_nxt;
      r_tx_en       <= w_tx_en_nxt;
      r_req_ack     <= w_req_ack_nxt;
      r_wdata       <= w_wdata_nxt;
      r_grant_id    <= w_grant_id_nxt;
      r_last_grant  <= w_last_grant_nxt;
      r_busy        <= (w_state_nxt != S_IDLE);
      r_timeout_err <= w_timeout_err_nxt;
      r_hold_cnt    <= w_hold_cnt_nxt;
      r_wait_cnt    <= w_wait_cnt_nxt;
    end
  end

  assign bus.tx_en       = r_tx_en;
  assign bus.req_ack     = r_req_ack;
  assign bus.waddr       = 3'd0;
  assign bus.wdata       = r_wdata;
  assign bus.busy        = r_busy;
  assign bus.grant_id    = r_grant_id;
  assign bus.timeout_err = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Self-checking bench for uart_tx_arbiter: directed vector
//               table, hand-written reset/timeout/fairness sequences, and a
//               randomized run against a timing-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx_arbiter;

  localparam int          NREQ    = 3;
  localparam int          HOLDOFF = 4;
  localparam logic [19:0] TIMEOUT = 20'd40;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  uart_tx_arbiter_if #(.NREQ(NREQ)) bus ();

  uart_tx_arbiter #(
    .NREQ    (NREQ),
    .HOLDOFF (HOLDOFF),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got running, required finished");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [2:0]  valid;
    logic [23:0] data;
    logic        rdy_n;
    logic        clr;
    logic        tx_en;
    logic [2:0]  ack;
    logic [7:0]  wdata;
    logic [1:0]  grant;
    logic        busy;
    logic        terr;
  } vec_t;

  vec_t tbl [12];

  task automatic check_outputs(input string name, input logic etx, input logic [2:0] eack,
                               input logic [7:0] ewd, input logic [1:0] egr,
                               input logic ebusy, input logic eterr);
    n_checks++;
    if (bus.tx_en !== etx || bus.req_ack !== eack || bus.wdata !== ewd ||
        bus.grant_id !== egr || bus.busy !== ebusy || bus.timeout_err !== eterr ||
        bus.waddr !== 3'd0) begin
      n_errors++;
      $display("FAIL %s: got tx_en=%b ack=%b wdata=%h grant=%0d busy=%b terr=%b waddr=%0d, required tx_en=%b ack=%b wdata=%h grant=%0d busy=%b terr=%b waddr=0",
               name, bus.tx_en, bus.req_ack, bus.wdata, bus.grant_id, bus.busy,
               bus.timeout_err, bus.waddr, etx, eack, ewd, egr, ebusy, eterr);
    end
  endtask

  task automatic check_val(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  // Reference model: tracks only "idle" and the age of the current byte in
  // cycles since its write strobe; ages 1..HOLDOFF are hold-off, later ages wait.
  int         m_idle, m_age, m_last, m_grant;
  logic [7:0] m_wdata;
  logic       m_terr, m_tx_en;
  logic [2:0] m_ack;

  task automatic model_reset();
    m_idle = 1; m_age = 0; m_last = NREQ - 1; m_grant = 0;
    m_wdata = 8'h00; m_terr = 1'b0; m_tx_en = 1'b0; m_ack = 3'b000;
  endtask

  task automatic model_step(input logic [2:0] v, input logic [23:0] d,
                            input logic rn, input logic clr);
    int a;
    m_tx_en = 1'b0;
    m_ack   = 3'b000;
    if (clr) m_terr = 1'b0;
    if (m_idle == 1) begin
      if (!rn) begin
        for (int k = 1; k <= NREQ; k++) begin
          int i;
          i = (m_last + k) % NREQ;
          if (m_idle == 1 && v[i]) begin
            m_idle  = 0;
            m_age   = 0;
            m_grant = i;
            m_wdata = d[i*8 +: 8];
            m_tx_en = 1'b1;
            m_ack   = 3'(1 << i);
          end
        end
      end
    end else begin
      a = m_age;
      m_age++;
      if (a > HOLDOFF) begin
        if (!rn) begin
          m_idle = 1; m_last = m_grant;
        end else if (a - HOLDOFF - 1 == int'(TIMEOUT) - 1) begin
          m_idle = 1; m_last = m_grant; m_terr = 1'b1;
        end
      end
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [23:0] d,
                       input logic rn, input logic clr);
    bus.req_valid = v;
    bus.req_data  = d;
    bus.tx_rdy_n  = rn;
    bus.err_clr   = clr;
  endtask

  initial begin
    int cnt, n_ev, cyc, last_cyc;
    logic [2:0]  rv;
    logic [23:0] rd;
    logic        busy_mode, rn, clr;
    logic [7:0]  fair_bytes [3];

    n_checks = 0;
    n_errors = 0;

    //              valid   data        rn clr  tx  ack     wdata  gr    busy terr
    tbl[0]  = '{3'b010, 24'h000600, 0, 0,  1, 3'b010, 8'h06, 2'd1, 1, 0}; // single request
    tbl[1]  = '{3'b000, 24'h000000, 0, 0,  0, 3'b000, 8'h06, 2'd1, 1, 0}; // hold 1
    tbl[2]  = '{3'b100, 24'h770000, 0, 0,  0, 3'b000, 8'h06, 2'd1, 1, 0}; // hold 2, req 2 blips
    tbl[3]  = '{3'b000, 24'h000000, 0, 0,  0, 3'b000, 8'h06, 2'd1, 1, 0}; // hold 3
    tbl[4]  = '{3'b000, 24'h000000, 0, 0,  0, 3'b000, 8'h06, 2'd1, 1, 0}; // hold 4
    tbl[5]  = '{3'b000, 24'h000000, 1, 0,  0, 3'b000, 8'h06, 2'd1, 1, 0}; // waiting for UART
    tbl[6]  = '{3'b000, 24'h000000, 0, 0,  0, 3'b000, 8'h06, 2'd1, 0, 0}; // UART ready -> idle
    tbl[7]  = '{3'b001, 24'h0000A5, 1, 0,  0, 3'b000, 8'h06, 2'd1, 0, 0}; // UART busy, no grant
    tbl[8]  = '{3'b001, 24'h0000A5, 1, 0,  0, 3'b000, 8'h06, 2'd1, 0, 0};
    tbl[9]  = '{3'b001, 24'h0000A5, 0, 0,  1, 3'b001, 8'hA5, 2'd0, 1, 0}; // ready -> grant 0
    tbl[10] = '{3'b000, 24'h000000, 1, 0,  0, 3'b000, 8'hA5, 2'd0, 1, 0}; // hold 1
    tbl[11] = '{3'b000, 24'h000000, 1, 0,  0, 3'b000, 8'hA5, 2'd0, 1, 0}; // hold 2

    rst = 1'b1;
    drive(3'b000, 24'h0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check_outputs("reset_state", 0, 3'b000, 8'h00, 2'd0, 0, 0);
    rst = 1'b0;

    for (int r = 0; r < 12; r++) begin
      drive(tbl[r].valid, tbl[r].data, tbl[r].rdy_n, tbl[r].clr);
      @(negedge clk);
      check_outputs($sformatf("vector_%0d", r), tbl[r].tx_en, tbl[r].ack, tbl[r].wdata,
                    tbl[r].grant, tbl[r].busy, tbl[r].terr);
    end

    // Reset during the second hold cycle clears everything without waiting for a clock.
    rst = 1'b1;
    #1;
    check_outputs("reset_mid_hold", 0, 3'b000, 8'h00, 2'd0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    drive(3'b111, 24'h443316, 1'b0, 1'b0);
    @(negedge clk);
    check_outputs("first_after_reset", 1, 3'b001, 8'h16, 2'd0, 1, 0);

    // UART never becomes ready: byte is abandoned after hold-off plus TIMEOUT cycles.
    drive(3'b000, 24'h0, 1'b1, 1'b0);
    cnt = 0;
    while (cnt < 200) begin
      @(negedge clk);
      cnt++;
      if (!bus.busy) break;
    end
    check_val("timeout_cycles", cnt, HOLDOFF + 1 + int'(TIMEOUT));
    check_outputs("timeout_state", 0, 3'b000, 8'h16, 2'd0, 0, 1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check_outputs("err_clr", 0, 3'b000, 8'h16, 2'd0, 0, 0);

    // Fairness: all requesters always valid, UART always ready.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    fair_bytes[0] = 8'hA1; fair_bytes[1] = 8'hB2; fair_bytes[2] = 8'hC3;
    drive(3'b111, 24'hC3B2A1, 1'b0, 1'b0);
    n_ev = 0; cyc = 0; last_cyc = 0;
    while (n_ev < 6 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (bus.tx_en) begin
        check_val($sformatf("fair_grant_%0d", n_ev), int'(bus.grant_id), n_ev % 3);
        check_val($sformatf("fair_wdata_%0d", n_ev), int'(bus.wdata), int'(fair_bytes[n_ev % 3]));
        if (n_ev > 0) begin
          n_checks++;
          if (cyc - last_cyc < HOLDOFF + 2) begin
            n_errors++;
            $display("FAIL fair_spacing_%0d: got %0d cycles, required at least %0d",
                     n_ev, cyc - last_cyc, HOLDOFF + 2);
          end
        end
        last_cyc = cyc;
        n_ev++;
      end
    end
    check_val("fair_grant_count", n_ev, 6);

    // Randomized traffic against the reference model.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    rv = 3'b000; rd = 24'h0; busy_mode = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (rv[i] && m_ack[i]) begin
          rv[i] = ($urandom_range(0, 1) == 0);
          rd[i*8 +: 8] = 8'($urandom);
        end else if (!rv[i] && $urandom_range(0, 3) == 0) begin
          rv[i] = 1'b1;
          rd[i*8 +: 8] = 8'($urandom);
        end else if (rv[i] && $urandom_range(0, 39) == 0) begin
          rv[i] = 1'b0;
        end
      end
      if ($urandom_range(0, 59) == 0) busy_mode = !busy_mode;
      rn  = busy_mode ? 1'b1 : ($urandom_range(0, 3) == 0);
      clr = ($urandom_range(0, 24) == 0);
      drive(rv, rd, rn, clr);
      model_step(rv, rd, rn, clr);
      @(negedge clk);
      check_outputs($sformatf("random_%0d", c), m_tx_en, m_ack, m_wdata, 2'(m_grant),
                    (m_idle == 0), m_terr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
